// File: rtl/encdec_pkg.sv
// Shared constants and FSM encoding for the one-hot encode/decode family.
package encdec_pkg;
  localparam int ENC_N = 64;
  localparam int ENC_W = 6;

  typedef enum logic {
    IDLE = 1'b0,
    EMIT = 1'b1
  } enc_state_t;
endpackage

// File: rtl/lsb_encoder.sv
// Combinational lowest-set-bit encoder: 8-bit group encoders plus a group-select stage.
// Reports the index, whether any bit is set, and whether exactly one bit is set.
module lsb_encoder #(
  parameter int N = 64,
  localparam int W = $clog2(N)
) (
  input  logic [N-1:0] vec,
  output logic [W-1:0] idx,
  output logic         any,
  output logic         single
);
  localparam int GS = (N < 8) ? N : 8;
  localparam int NG = N / GS;

  logic [NG-1:0] g_any;
  logic [NG-1:0] g_single;
  logic [W-1:0]  g_idx [NG];

  function automatic logic [W-1:0] grp_lsb(input logic [GS-1:0] v);
    logic [W-1:0] r;
    r = '0;
    for (int b = GS - 1; b >= 0; b--) begin
      if (v[b]) r = W'(b);
    end
    return r;
  endfunction

  // Group bases are GS-aligned, so OR-ing in the local index forms the full index.
  for (genvar g = 0; g < NG; g++) begin : g_grp
    logic [GS-1:0] s;
    assign s           = vec[g*GS +: GS];
    assign g_any[g]    = |s;
    assign g_single[g] = (s != '0) && ((s & (s - GS'(1))) == '0);
    assign g_idx[g]    = grp_lsb(s) | W'(g * GS);
  end

  always_comb begin
    idx = '0;
    for (int g = NG - 1; g >= 0; g--) begin
      if (g_any[g]) idx = g_idx[g];
    end
  end

  assign any    = |g_any;
  assign single = ((g_any & (g_any - NG'(1))) == '0) && |(g_any & g_single);
endmodule

// File: rtl/onehot_scan_encoder.sv
// Captures an N-bit vector and replays its set-bit indices lowest first, one per out beat.
// First beat one cycle after acceptance; holds beat stable under out_ready=0; one bubble between vectors.
module onehot_scan_encoder
  import encdec_pkg::*;
#(
  parameter int N = ENC_N,
  parameter int W = ENC_W
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         flush,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] in_vec,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_idx,
  output logic         out_last
);
  enc_state_t   state_q, state_d;
  logic [N-1:0] pend_q, pend_d;
  logic [W-1:0] enc_idx;
  logic         enc_any;
  logic         enc_single;

  lsb_encoder #(.N(N)) u_lsb (
    .vec    (pend_q),
    .idx    (enc_idx),
    .any    (enc_any),
    .single (enc_single)
  );

  assign in_ready  = rst_n && !flush && (state_q == IDLE);
  assign out_valid = rst_n && (state_q == EMIT) && enc_any;
  assign out_idx   = out_valid ? enc_idx : '0;
  assign out_last  = out_valid && enc_single;

  always_comb begin
    state_d = state_q;
    pend_d  = pend_q;
    if (flush) begin
      // A handshake coinciding with flush is dropped along with the vector.
      state_d = IDLE;
      pend_d  = '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (in_valid && in_ready && (in_vec != '0)) begin
            pend_d  = in_vec;
            state_d = EMIT;
          end
        end
        EMIT: begin
          if (out_valid && out_ready) begin
            pend_d = pend_q & (pend_q - N'(1));
            if (out_last) state_d = IDLE;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      pend_q  <= '0;
    end else begin
      state_q <= state_d;
      pend_q  <= pend_d;
    end
  end
endmodule

// File: tb/tb_onehot_scan_encoder.sv
// Scoreboard bench: accepted vectors expand into expected beats, checked every cycle on the falling edge.
module tb_onehot_scan_encoder;
  localparam int N = 64;
  localparam int W = 6;

  typedef struct packed {
    logic         last;
    logic [W-1:0] idx;
  } beat_t;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         flush;
  logic         in_valid;
  logic         in_ready;
  logic [N-1:0] in_vec;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_idx;
  logic         out_last;

  beat_t exp_q[$];
  int    n_vec  = 0;
  int    n_miss = 0;
  logic  tog    = 1'b0;

  always #5 clk = ~clk;

  onehot_scan_encoder #(.N(N), .W(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_vec    (in_vec),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_idx   (out_idx),
    .out_last  (out_last)
  );

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h, expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: state is exactly the queue of beats still owed.
  always @(negedge clk) begin
    logic exp_rdy, exp_vld;
    int   top;
    exp_rdy = rst_n && !flush && (exp_q.size() == 0);
    exp_vld = rst_n && (exp_q.size() != 0);
    check_eq("in_ready", 64'(in_ready), 64'(exp_rdy));
    check_eq("out_valid", 64'(out_valid), 64'(exp_vld));
    if (exp_vld) begin
      check_eq("out_idx", 64'(out_idx), 64'(exp_q[0].idx));
      check_eq("out_last", 64'(out_last), 64'(exp_q[0].last));
    end else begin
      check_eq("out_idx_idle", 64'(out_idx), 64'd0);
      check_eq("out_last_idle", 64'(out_last), 64'd0);
    end
    if (!rst_n || flush) begin
      exp_q.delete();
    end else begin
      if (exp_vld && out_ready) void'(exp_q.pop_front());
      if (exp_rdy && in_valid && (in_vec != '0)) begin
        top = 0;
        for (int i = 0; i < N; i++) if (in_vec[i]) top = i;
        for (int i = 0; i < N; i++)
          if (in_vec[i]) exp_q.push_back('{last: (i == top), idx: W'(i)});
      end
    end
  end

  task automatic send(input logic [N-1:0] v);
    bit ok;
    ok       = 1'b0;
    in_valid = 1'b1;
    in_vec   = v;
    for (int c = 0; c < 200 && !ok; c++) begin
      @(negedge clk);
      if (in_ready) ok = 1'b1;
    end
    if (!ok) check_eq("send_timeout", 64'd1, 64'd0);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_vec   = '0;
  endtask

  task automatic wait_idle();
    bit ok;
    ok = 1'b0;
    for (int c = 0; c < 400 && !ok; c++) begin
      @(negedge clk);
      if (exp_q.size() == 0) ok = 1'b1;
    end
    if (!ok) check_eq("drain_timeout", 64'd1, 64'd0);
    @(posedge clk);
    #1;
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    fork
      forever begin
        @(posedge clk);
        #1;
        if (tog) out_ready = !out_ready;
      end
    join_none

    rst_n     = 1'b0;
    flush     = 1'b0;
    in_valid  = 1'b0;
    in_vec    = '0;
    out_ready = 1'b1;
    step(3);
    rst_n = 1'b1;
    step(1);

    send(64'd1 << 37);
    wait_idle();

    tog = 1'b1;
    send(64'h8000_0000_0000_0105);
    wait_idle();
    tog       = 1'b0;
    out_ready = 1'b1;

    send({N{1'b1}});
    wait_idle();

    send(64'd0);
    step(2);
    send(64'h10);
    wait_idle();

    // Flush after beats 4 and 5, with a competing vector offered.
    send(64'hF0);
    step(2);
    flush    = 1'b1;
    in_valid = 1'b1;
    in_vec   = 64'hFF;
    step(1);
    flush    = 1'b0;
    in_valid = 1'b0;
    in_vec   = '0;
    step(3);

    // Reset pulse in the middle of an emit sequence.
    send(64'hF0);
    step(1);
    rst_n = 1'b0;
    step(1);
    rst_n = 1'b1;
    step(3);
    send(64'h3);
    wait_idle();

    // Boundary: top bit alone.
    send(64'h8000_0000_0000_0000);
    wait_idle();
    step(2);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end
endmodule
